// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine between NREQ burst requesters.
// Sequences start/done per byte, returns received bytes, and aborts hung bytes via a watchdog.
module spi_burst_arbiter #(
    parameter int NREQ    = 2,
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   len,
    input  logic [NREQ*8-1:0]       tx_data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         tx_ready,
    output logic [7:0]              rx_data,
    output logic [NREQ-1:0]         rx_valid,
    output logic [NREQ-1:0]         burst_done,
    output logic [NREQ-1:0]         err,
    output logic                    m_start,
    output logic [7:0]              m_wr_data,
    input  logic [7:0]              m_rd_data,
    input  logic                    m_done
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_FIN} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, gidx, pick_idx;
    logic               pick_found;
    logic [LEN_W-1:0]   rem;
    logic [TMR_W-1:0]   timer;
    logic [GAP_W-1:0]   gcnt;
    logic               tmo_hit, gap_last;
    logic               launch, got_done, abort, finish;
    logic [NREQ-1:0]    tx_ready_nx, rx_valid_nx, done_nx, err_nx;

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req[(int'(ptr) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign tmo_hit = (timer == TMR_W'(TMO_CYC - 1));
    // m_start is registered out of LAUNCH, so the LAUNCH cycle is itself one of the
    // GAP_CYC idle cycles seen on the interface; GAP only covers the remainder.
    assign gap_last = (int'(gcnt) >= GAP_CYC - 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (pick_found) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (m_done) begin
                    if (rem == '0)        state_nx = S_FIN;
                    else if (GAP_CYC < 2) state_nx = S_LAUNCH;
                    else                  state_nx = S_GAP;
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_GAP:    if (gap_last) state_nx = S_LAUNCH;
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        launch      = (state == S_LAUNCH);
        got_done    = (state == S_WAIT) && m_done;
        abort       = (state == S_WAIT) && !m_done && tmo_hit;
        finish      = (state == S_FIN);
        tx_ready_nx = launch   ? gnt : '0;
        rx_valid_nx = got_done ? gnt : '0;
        done_nx     = finish   ? gnt : '0;
        err_nx      = abort    ? gnt : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt        <= '0;
            gidx       <= '0;
            ptr        <= '0;
            rem        <= '0;
            timer      <= '0;
            gcnt       <= '0;
            m_start    <= 1'b0;
            m_wr_data  <= '0;
            rx_data    <= '0;
            tx_ready   <= '0;
            rx_valid   <= '0;
            burst_done <= '0;
            err        <= '0;
        end else begin
            m_start    <= launch;
            tx_ready   <= tx_ready_nx;
            rx_valid   <= rx_valid_nx;
            burst_done <= done_nx;
            err        <= err_nx;

            if (state == S_IDLE && pick_found) begin
                gnt  <= ONE << pick_idx;
                gidx <= pick_idx;
                rem  <= len[pick_idx*LEN_W +: LEN_W];
            end
            if (launch) begin
                m_wr_data <= tx_data[gidx*8 +: 8];
                timer     <= '0;
            end
            if (state == S_WAIT) begin
                timer <= timer + 1'b1;
                gcnt  <= '0;
            end
            if (state == S_GAP) gcnt <= gcnt + 1'b1;
            if (got_done) begin
                rx_data <= m_rd_data;
                if (rem != '0) rem <= rem - 1'b1;
            end
            if (finish || abort) begin
                gnt <= '0;
                ptr <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Scoreboard bench for spi_burst_arbiter with a fixed-latency done model standing in for spi_master.
// Byte 8'h77 is never answered by the done model, which exercises the watchdog.
module tb_spi_burst_arbiter;
    localparam int NREQ    = 2;
    localparam int LEN_W   = 4;
    localparam int GAP_CYC = 2;
    localparam int TMO_CYC = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LEN_W-1:0] len = '0;
    logic [NREQ*8-1:0]     tx_data;
    logic [NREQ-1:0]       gnt, tx_ready, rx_valid, burst_done, err;
    logic [7:0]            rx_data, m_wr_data, m_rd_data;
    logic                  m_start, m_done;

    spi_burst_arbiter #(
        .NREQ(NREQ), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .tx_data(tx_data),
        .gnt(gnt), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .burst_done(burst_done), .err(err), .m_start(m_start), .m_wr_data(m_wr_data),
        .m_rd_data(m_rd_data), .m_done(m_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] exp_start[$];
    logic [15:0] exp_rx[$];
    logic [3:0]  exp_end[$];

    logic [7:0] bytes_r [NREQ][16];
    int         pos [NREQ];
    int         n_start = 0;
    int         last_done_cyc = 0, last_rx_cyc = 0, last_start_cyc = 0;
    bit         pend_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < NREQ; i++) tx_data[i*8 +: 8] = bytes_r[i][pos[i] & 15];
    end

    // Done model: answers each m_start three cycles later with wr_data ^ 8'h5A.
    int         dm_cnt = 0;
    logic [7:0] dm_byte = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_cnt    <= 0;
            m_done    <= 1'b0;
            m_rd_data <= '0;
        end else begin
            m_done <= 1'b0;
            if (dm_cnt != 0) begin
                dm_cnt <= dm_cnt - 1;
                if (dm_cnt == 1) begin
                    m_done    <= 1'b1;
                    m_rd_data <= dm_byte ^ 8'h5A;
                end
            end else if (m_start && m_wr_data != 8'h77) begin
                dm_cnt  <= 3;
                dm_byte <= m_wr_data;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin : mon
        logic [15:0] e;
        logic [3:0]  ee;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) pos[i] <= 0;
            pend_gap <= 1'b0;
        end else begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (tx_ready[i]) pos[i] <= pos[i] + 1;
                if (burst_done[i] || err[i]) pos[i] <= 0;
            end
            if (m_start) begin
                n_start        <= n_start + 1;
                last_start_cyc <= cyc;
                check("tx_ready_with_start", 32'(tx_ready), 32'(gnt));
                if (pend_gap) check("gap_cycles", cyc - last_done_cyc, GAP_CYC + 1);
                if (exp_start.size() == 0) check("start_unexpected", 1, 0);
                else begin
                    e = exp_start.pop_front();
                    check("start_gnt", 32'(gnt), 32'(e[15:8]));
                    check("start_byte", 32'(m_wr_data), 32'(e[7:0]));
                end
            end else if (tx_ready != '0) begin
                check("tx_ready_without_start", 32'(tx_ready), 0);
            end
            if (m_done) begin
                pend_gap      <= 1'b1;
                last_done_cyc <= cyc;
            end
            if (rx_valid != '0) begin
                last_rx_cyc <= cyc;
                if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
                else begin
                    e = exp_rx.pop_front();
                    check("rx_valid", 32'(rx_valid), 32'(e[15:8]));
                    check("rx_data", 32'(rx_data), 32'(e[7:0]));
                end
            end
            if ((burst_done | err) != '0) begin
                pend_gap <= 1'b0;
                check("gnt_clear_at_end", 32'(gnt), 0);
                if (burst_done != '0) check("done_after_rx", cyc - last_rx_cyc, 1);
                if (err != '0) check("err_after_start", cyc - last_start_cyc, TMO_CYC);
                if (exp_end.size() == 0) check("end_unexpected", 1, 0);
                else begin
                    ee = exp_end.pop_front();
                    check("end_code", 32'({err, burst_done}), 32'(ee));
                end
            end
        end
    end

    task automatic start_burst(input int r, input int n, input logic [7:0] b[4], input bit hang);
        logic [1:0] oh;
        oh = 2'(1 << r);
        for (int k = 0; k < n; k++) begin
            bytes_r[r][k] = b[k];
            exp_start.push_back({6'b0, oh, b[k]});
            if (!hang) exp_rx.push_back({6'b0, oh, b[k] ^ 8'h5A});
        end
        exp_end.push_back(hang ? {oh, 2'b00} : {2'b00, oh});
        len[r*LEN_W +: LEN_W] = LEN_W'(n - 1);
    endtask

    task automatic wait_end(input int r);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (burst_done[r] || err[r]) begin
                got = 1'b1;
                break;
            end
        end
        check("burst_end_seen", 32'(got), 1);
        req[r] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_pulses"}, 32'({m_start, tx_ready, rx_valid, burst_done, err}), 0);
        check({tag, "_wr_data"}, 32'(m_wr_data), 0);
        check({tag, "_rx_data"}, 32'(rx_data), 0);
    endtask

    initial begin
        int  req_cyc;
        int  base;
        bit  seen;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 16; k++) bytes_r[i][k] = 8'h00;

        // Reset held for 20 ns
        @(negedge clk);
        check_idle("reset");
        #10 rst = 1'b1;

        // Single-byte burst on requester 0
        @(negedge clk);
        start_burst(0, 1, '{8'hCA, 8'h00, 8'h00, 8'h00}, 1'b0);
        req[0] = 1'b1;
        req_cyc = cyc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_start) break;
        end
        check("first_start_latency", cyc - req_cyc, 2);
        check("single_gnt", 32'(gnt), 32'h1);
        wait_end(0);

        // Three-byte burst on requester 1
        @(negedge clk);
        start_burst(1, 3, '{8'hA5, 8'h3C, 8'hF0, 8'h00}, 1'b0);
        req[1] = 1'b1;
        wait_end(1);

        // Simultaneous requests, then req0 re-requests during req1's burst
        @(negedge clk);
        start_burst(0, 2, '{8'h11, 8'h22, 8'h00, 8'h00}, 1'b0);
        start_burst(1, 2, '{8'h33, 8'h44, 8'h00, 8'h00}, 1'b0);
        req = 2'b11;
        wait_end(0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (gnt == 2'b10) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rr_second_gnt", 32'(seen), 1);
        start_burst(0, 1, '{8'h55, 8'h00, 8'h00, 8'h00}, 1'b0);
        req[0] = 1'b1;
        wait_end(1);
        wait_end(0);

        // Watchdog on requester 1, requester 0 served afterwards
        @(negedge clk);
        start_burst(1, 1, '{8'h77, 8'h00, 8'h00, 8'h00}, 1'b1);
        start_burst(0, 1, '{8'h19, 8'h00, 8'h00, 8'h00}, 1'b0);
        req = 2'b11;
        wait_end(1);
        wait_end(0);

        // Reset during the second byte of a three-byte burst
        @(negedge clk);
        start_burst(0, 3, '{8'h21, 8'h42, 8'h63, 8'h00}, 1'b0);
        req[0] = 1'b1;
        base = n_start;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (n_start >= base + 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("second_byte_reached", 32'(seen), 1);
        rst = 1'b0;
        req = '0;
        #1;
        check_idle("async_reset");
        exp_start.delete();
        exp_rx.delete();
        exp_end.delete();
        #19 rst = 1'b1;

        // After reset the pointer restarts at requester 0
        @(negedge clk);
        start_burst(0, 1, '{8'h5E, 8'h00, 8'h00, 8'h00}, 1'b0);
        start_burst(1, 1, '{8'hE5, 8'h00, 8'h00, 8'h00}, 1'b0);
        req = 2'b11;
        wait_end(0);
        wait_end(1);

        // req0 dropped after the first tx_ready; burst still completes
        @(negedge clk);
        start_burst(0, 2, '{8'h0F, 8'hF1, 8'h00, 8'h00}, 1'b0);
        req[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_ready[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("drop_tx_ready_seen", 32'(seen), 1);
        req[0] = 1'b0;
        wait_end(0);

        repeat (5) @(negedge clk);
        check("left_start", exp_start.size(), 0);
        check("left_rx", exp_rx.size(), 0);
        check("left_end", exp_end.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
